mwpipe_hs: RTL and testbench

MWPIPE_HS -- requirements
Module: mwpipe_hs

---
 rtl/mwpipe_hs_if.sv | 17 +
 rtl/mwpipe_hs.sv | 92 +++++++++
 tb/tb_mwpipe_hs.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mwpipe_hs_if.sv
// mwpipe_hs_if: Memory->Writeback handshake bundle; the stage uses slave, its environment uses master.
interface mwpipe_hs_if #(parameter int N = 32, parameter int M = 4);
  logic         valid_M, ready_M, pcload_M, regw_M, regmem_M;
  logic [M-1:0] regScr_M;
  logic [N-1:0] ALUrslt_M, memData_M;
  logic         valid_W, ready_W, pcload_W, regw_W, regmem_W;
  logic [M-1:0] regScr_W;
  logic [N-1:0] ALUrslt_W, memData_W, wbData_W;
  modport master (
    output valid_M, pcload_M, regw_M, regmem_M, regScr_M, ALUrslt_M, memData_M, ready_W,
    input  ready_M, valid_W, pcload_W, regw_W, regmem_W, regScr_W, ALUrslt_W, memData_W, wbData_W
  );
  modport slave (
    input  valid_M, pcload_M, regw_M, regmem_M, regScr_M, ALUrslt_M, memData_M, ready_W,
    output ready_M, valid_W, pcload_W, regw_W, regmem_W, regScr_W, ALUrslt_W, memData_W, wbData_W
  );
endinterface

// File: rtl/mwpipe_hs.sv
// mwpipe_hs: Memory->Writeback pipeline register with valid/ready handshake and flush.
// Define MWPIPE_SKID_EN for a two-entry skid buffer with a registered ready_M.
module mwpipe_hs #(
  parameter int N = 32,
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  mwpipe_hs_if.slave   bus
);
  typedef struct packed {
    logic         pcload;
    logic         regw;
    logic         regmem;
    logic [M-1:0] scr;
    logic [N-1:0] alu;
    logic [N-1:0] mem;
    logic [N-1:0] wb;
  } entry_t;
  entry_t in_e, main_q, main_d;
  logic   v_q, v_d, acc, rel;
  always_comb in_e = '{pcload: bus.pcload_M, regw: bus.regw_M, regmem: bus.regmem_M,
                       scr: bus.regScr_M, alu: bus.ALUrslt_M, mem: bus.memData_M,
                       wb: bus.regmem_M ? bus.memData_M : bus.ALUrslt_M};
  assign acc = bus.valid_M && bus.ready_M;
  assign rel = v_q && bus.ready_W;
`ifdef MWPIPE_SKID_EN
  entry_t skid_q, skid_d;
  logic   sv_q, sv_d, rdy_q;
  assign bus.ready_M = rdy_q;
  always_comb begin
    v_d    = v_q;
    sv_d   = sv_q;
    main_d = main_q;
    skid_d = skid_q;
    if (!v_q || rel) begin
      main_d = sv_q ? skid_q : acc ? in_e : main_q;
      v_d    = sv_q || acc;
      sv_d   = 1'b0;
    end else if (acc) begin
      skid_d = in_e;
      sv_d   = 1'b1;
    end
    if (flush) begin
      v_d  = 1'b0;
      sv_d = 1'b0;
    end
    if (!v_d) begin
      main_d.pcload = 1'b0;
      main_d.regw   = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sv_q   <= 1'b0;
      skid_q <= '0;
      rdy_q  <= 1'b1;
    end else begin
      sv_q   <= sv_d;
      skid_q <= skid_d;
      rdy_q  <= !sv_d;
    end
`else
  assign bus.ready_M = !v_q || bus.ready_W;
  always_comb begin
    v_d    = acc ? 1'b1 : rel ? 1'b0 : v_q;
    main_d = acc ? in_e : main_q;
    if (flush) v_d = 1'b0;
    if (!v_d) begin
      main_d.pcload = 1'b0;
      main_d.regw   = 1'b0;
    end
  end
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      v_q    <= 1'b0;
      main_q <= '0;
    end else begin
      v_q    <= v_d;
      main_q <= main_d;
    end
  assign bus.valid_W   = v_q;
  assign bus.pcload_W  = main_q.pcload;
  assign bus.regw_W    = main_q.regw;
  assign bus.regmem_W  = main_q.regmem;
  assign bus.regScr_W  = main_q.scr;
  assign bus.ALUrslt_W = main_q.alu;
  assign bus.memData_W = main_q.mem;
  assign bus.wbData_W  = main_q.wb;
endmodule

// File: tb/tb_mwpipe_hs.sv
// tb_mwpipe_hs: directed self-checking bench for mwpipe_hs, valid with or without MWPIPE_SKID_EN.
module tb_mwpipe_hs;
  localparam int N = 32;
  localparam int M = 4;
`ifdef MWPIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  int   checks = 0;
  int   errors = 0;
  mwpipe_hs_if #(.N(N), .M(M)) bus();
  mwpipe_hs #(.N(N), .M(M)) dut (.clk(clk), .rst(rst), .flush(flush), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [N-1:0] alu, input logic [N-1:0] mem, input logic rm);
    bus.valid_M   = v;
    bus.ALUrslt_M = alu;
    bus.memData_M = mem;
    bus.regmem_M  = rm;
    bus.regw_M    = v;
    bus.pcload_M  = v;
    bus.regScr_M  = alu[M-1:0];
  endtask
  initial begin
    logic [N-1:0] items [3];
    logic [N-1:0] expw [5];
    logic [3:0]   exprdy;
    logic         take;
    int           idx;
    items  = '{32'hA, 32'hB, 32'hC};
    expw   = '{32'hA, 32'hA, 32'hA, 32'hB, 32'hC};
    exprdy = SKID ? 4'b1001 : 4'b1100;
    bus.ready_W = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    // reset held with random activity on every input
    repeat (4) begin
      @(negedge clk);
      drive(1'($urandom), $urandom, $urandom, 1'($urandom));
      bus.ready_W = 1'($urandom);
      flush = 1'($urandom);
    end
    #1;
    check("rst_valid", bus.valid_W, 0);
    check("rst_regw", bus.regw_W, 0);
    check("rst_pcload", bus.pcload_W, 0);
    check("rst_regmem", bus.regmem_W, 0);
    check("rst_scr", bus.regScr_W, 0);
    check("rst_wb", bus.wbData_W, 0);
    check("rst_alu", bus.ALUrslt_W, 0);
    check("rst_mem", bus.memData_W, 0);
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b0);
    flush = 1'b0;
    bus.ready_W = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_ready", bus.ready_M, 1);
    check("post_rst_valid", bus.valid_W, 0);
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, N'(i), 32'hFFFF_0000, 1'b0);
      @(negedge clk);
      check("stream_valid", bus.valid_W, 1);
      check("stream_wb", bus.wbData_W, 64'(i));
      check("stream_regw", bus.regw_W, 1);
      check("stream_ready", bus.ready_M, 1);
    end
    drive(1'b0, '0, '0, 1'b0);
    @(negedge clk);
    check("drain_valid", bus.valid_W, 0);
    check("drain_regw", bus.regw_W, 0);
    check("drain_pcload", bus.pcload_W, 0);
    drive(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b1);
    @(negedge clk);
    check("load_wb", bus.wbData_W, 32'hDEAD_BEEF);
    check("load_alu", bus.ALUrslt_W, 32'h10);
    check("load_mem", bus.memData_W, 32'hDEAD_BEEF);
    check("load_regmem", bus.regmem_W, 1);
    check("load_scr", bus.regScr_W, 0);
    drive(1'b0, '0, '0, 1'b0);
    @(negedge clk);
    check("load_drain", bus.valid_W, 0);
    // stall: downstream refuses for three edges while upstream offers A,B,C
    idx = 0;
    bus.ready_W = 1'b0;
    for (int s = 0; s < 7; s++) begin
      if (s >= 1 && s <= 5) begin
        check("stall_valid", bus.valid_W, 1);
        check("stall_wb", bus.wbData_W, expw[s-1]);
        check("stall_alu", bus.ALUrslt_W, expw[s-1]);
      end
      if (s == 6) check("stall_drain", bus.valid_W, 0);
      if (s == 3) begin
        check("stall_taken", idx, SKID ? 2 : 1);
        bus.ready_W = 1'b1;
      end
      drive(idx < 3, idx < 3 ? items[idx] : '0, '0, 1'b0);
      #1;
      if (s >= 1 && s <= 4) check("stall_ready", bus.ready_M, exprdy[s-1]);
      take = bus.valid_M && bus.ready_M;
      @(negedge clk);
      if (take) idx++;
    end
    // flush with entries held, a new entry offered and the downstream releasing
    bus.ready_W = 1'b0;
    drive(1'b1, 32'hD, '0, 1'b0);
    @(negedge clk);
    check("fl_hold_valid", bus.valid_W, 1);
    check("fl_hold_wb", bus.wbData_W, 32'hD);
    drive(1'b1, 32'hE, '0, 1'b0);
    @(negedge clk);
    check("fl_hold_wb2", bus.wbData_W, 32'hD);
    flush = 1'b1;
    bus.ready_W = 1'b1;
    drive(1'b1, 32'hF, '0, 1'b0);
    @(negedge clk);
    flush = 1'b0;
    check("flush_valid", bus.valid_W, 0);
    check("flush_regw", bus.regw_W, 0);
    check("flush_pcload", bus.pcload_W, 0);
    drive(1'b0, '0, '0, 1'b0);
    @(negedge clk);
    check("flush_gone", bus.valid_W, 0);
    @(negedge clk);
    check("flush_gone2", bus.valid_W, 0);
    // asynchronous half-cycle reset while stalled
    bus.ready_W = 1'b0;
    drive(1'b1, 32'h33, 32'h44, 1'b0);
    @(negedge clk);
    check("ar_valid", bus.valid_W, 1);
    check("ar_wb", bus.wbData_W, 32'h33);
    drive(1'b0, '0, '0, 1'b0);
    @(negedge clk);
    check("ar_stall_wb", bus.wbData_W, 32'h33);
    rst = 1'b0;
    #1;
    check("ar_valid_now", bus.valid_W, 0);
    check("ar_regw_now", bus.regw_W, 0);
    check("ar_wb_now", bus.wbData_W, 0);
    check("ar_mem_now", bus.memData_W, 0);
    #3 rst = 1'b1;
    @(negedge clk);
    check("ar_after_valid", bus.valid_W, 0);
    check("ar_after_ready", bus.ready_M, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
